icache_line_fetcher: RTL and testbench
======================================

Name: icache_line_fetcher

Overview:
- Memory-side stage directly below the L1 I-cache.
- Accepts the cache's single-line miss request (strobe + address) and issues one AXI4 INCR read burst of CLSIZE/XLEN beats.
- Assembles the returned beats into one CLSIZE-bit line and returns it to the cache with a one-cycle ready pulse.
- Read-only; one outstanding request at a time.

Parameters:
- XLEN, 32, address width and AXI data (beat) width.
- CLSIZE, 256, cache line width in bits; must be a power-of-2 multiple of XLEN.
- N_BEATS, CLSIZE/XLEN (8), derived: beats per burst.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous active-high reset
- c_strobe_i  in  1  line request from I-cache (level; may stay high several cycles)
- c_addr_i  in  XLEN  request address; sampled only on acceptance
- c_ready_o  out  1  one-cycle pulse: c_data_o holds the completed line
- c_data_o  out  CLSIZE  assembled line, word 0 in the MSBs [CLSIZE-1 -: XLEN]
- err_o  out  1  sticky error: SLVERR/DECERR response or RLAST mismatch; cleared only by reset
- m_araddr_o  out  XLEN  burst start address, line-aligned
- m_arlen_o  out  8  fixed N_BEATS-1
- m_arburst_o  out  2  fixed 2'b01 (INCR)
- m_arsize_o  out  3  fixed log2(XLEN/8)
- m_arvalid_o  out  1  address valid
- m_arready_i  in  1  address accepted
- m_rdata_i  in  XLEN  read beat data
- m_rresp_i  in  2  read beat response
- m_rlast_i  in  1  last beat of burst
- m_rvalid_i  in  1  read beat valid
- m_rready_o  out  1  read beat ready

Behaviour:
- Reset (async, rst_i high): state IDLE. c_ready_o=0, c_data_o=0, err_o=0, m_arvalid_o=0, m_rready_o=0, m_araddr_o=0, beat counter=0. All outputs are registered.
- IDLE: when c_strobe_i=1, latch m_araddr_o = {c_addr_i[XLEN-1:log2(CLSIZE/8)], zeros}, assert m_arvalid_o and go to ADDR. Request latency is one cycle from strobe to arvalid.
- ADDR: hold m_arvalid_o and m_araddr_o stable until m_arready_i=1, which is the handshake cycle. Then deassert arvalid next cycle, assert m_rready_o, clear the beat counter and go to DATA.
- DATA: m_rready_o=1. On each rvalid&rready:
  - Write m_rdata_i into word slot [beat] (MSB-first).
  - Increment beat.
  - If rresp != 0, set err_o.
- DATA termination:
  - On beat == N_BEATS-1 accepted: go to DONE regardless of rlast. If rlast=0, set err_o.
  - If rlast=1 on an earlier beat: set err_o and go to DONE. Unfilled slots keep their previous contents; the line is still delivered.
- DONE: c_ready_o=1 for exactly one cycle, m_rready_o=0, go to HOLD. c_data_o stays stable until the first beat of the next request overwrites it.
- HOLD: one cycle in which c_strobe_i is ignored; this covers the cache's registered strobe still being high in the ready cycle. Then go to IDLE.
- Strobe while busy (ADDR/DATA/DONE/HOLD) is ignored; no queuing.
- Beats with rvalid=1 outside DATA are not accepted (rready=0).
- End-to-end latency: request accepted at T, arvalid at T+1, then 1 cycle after the last beat handshake until c_ready_o.
- Beat counter width is log2(N_BEATS) bits. Wrap is never used, because termination occurs at N_BEATS-1.
- Reset mid-burst returns to IDLE immediately. The memory slave shares rst_i, so no stale beats follow reset.

Decomposition:
- Shared package (aquila_pkg) holds:
  - CLSIZE, XLEN and derived N_BEATS/line byte offset bits.
  - AXI burst type constant INCR=2'b01.
  - Response codes OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11.
- One natural sub-module, line_packer: beat counter plus MSB-first word slot write into the CLSIZE register. The FSM stays in icache_line_fetcher.

Test Plan:
- Basic miss: strobe with c_addr_i=0x0000_1234, arready immediate, 8 beats 0x11111111..0x88888888 -> araddr=0x0000_1220, arlen=7, c_data_o=0x11111111_22222222_..._88888888, single c_ready_o pulse, err_o=0.
- Backpressure: arready held low 5 cycles, rvalid gapped (1 on/2 off) -> arvalid/araddr stable throughout, same assembled line, ready exactly once.
- Held strobe: c_strobe_i kept high 3 cycles after c_ready_o -> exactly one AR handshake per request; a new AR issues only after HOLD.
- Error response: beat 3 rresp=2'b10 -> line still delivered, err_o=1 and stays 1 across the next clean request.
- Early rlast on beat 5 -> c_ready_o after beat 5, slots 6-7 unchanged from previous line, err_o=1. Missing rlast on beat 7 -> completion still occurs, err_o=1.
- Async reset asserted mid-DATA (after beat 4) -> all outputs 0 without a clock edge; after release, a fresh request completes normally.

Source files
------------

// File: rtl/aquila_pkg.sv
// Shared constants and types for the memory-side line fetch path.
package aquila_pkg;
   localparam int XLEN     = 32;
   localparam int CLSIZE   = 256;
   localparam int N_BEATS  = CLSIZE / XLEN;
   localparam int LINE_OFS = $clog2(CLSIZE / 8);

   localparam logic [1:0] AXI_INCR    = 2'b01;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_DONE,
      S_HOLD
   } fetch_state_t;
endpackage

// File: rtl/line_packer.sv
// Beat counter plus MSB-first word slot write into the line register.
module line_packer #(
   parameter int XLEN   = 32,
   parameter int CLSIZE = 256,
   localparam int N_BEATS = CLSIZE / XLEN,
   localparam int BEAT_W  = $clog2(N_BEATS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              wr,
   input  logic [XLEN-1:0]   wdata,
   output logic [CLSIZE-1:0] line,
   output logic [BEAT_W-1:0] beat
);

   // Word 0 lands in the MSBs; slots not written keep the previous line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line <= '0;
         beat <= '0;
      end else if (clr) begin
         beat <= '0;
      end else if (wr) begin
         line[CLSIZE-1 - int'(beat)*XLEN -: XLEN] <= wdata;
         beat <= beat + 1'b1;
      end
   end

endmodule

// File: rtl/icache_line_fetcher.sv
// Turns an I-cache line miss into one AXI4 INCR read burst and returns the
// assembled line with a single-cycle ready pulse.
import aquila_pkg::*;

module icache_line_fetcher #(
   parameter int XLEN   = aquila_pkg::XLEN,
   parameter int CLSIZE = aquila_pkg::CLSIZE
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              c_strobe_i,
   input  logic [XLEN-1:0]   c_addr_i,
   output logic              c_ready_o,
   output logic [CLSIZE-1:0] c_data_o,
   output logic              err_o,
   output logic [XLEN-1:0]   m_araddr_o,
   output logic [7:0]        m_arlen_o,
   output logic [1:0]        m_arburst_o,
   output logic [2:0]        m_arsize_o,
   output logic              m_arvalid_o,
   input  logic              m_arready_i,
   input  logic [XLEN-1:0]   m_rdata_i,
   input  logic [1:0]        m_rresp_i,
   input  logic              m_rlast_i,
   input  logic              m_rvalid_i,
   output logic              m_rready_o
);

   localparam int N_BEATS  = CLSIZE / XLEN;
   localparam int BEAT_W   = $clog2(N_BEATS);
   localparam int LINE_OFS = $clog2(CLSIZE / 8);
   localparam logic [7:0] AR_LEN  = 8'(N_BEATS - 1);
   localparam logic [2:0] AR_SIZE = 3'($clog2(XLEN / 8));
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);

   fetch_state_t      state;
   logic [BEAT_W-1:0] beat;
   logic              beat_ok;
   logic              beat_clr;
   logic              last;
   logic              unused_addr_bits;

   assign m_arlen_o   = AR_LEN;
   assign m_arburst_o = AXI_INCR;
   assign m_arsize_o  = AR_SIZE;

   assign beat_ok  = (state == S_DATA) && m_rvalid_i && m_rready_o;
   assign beat_clr = (state == S_ADDR) && m_arready_i;
   assign last     = (beat == LAST_BEAT);

   // Byte offset within the line is dropped by alignment.
   assign unused_addr_bits = ^c_addr_i[LINE_OFS-1:0];

   line_packer #(
      .XLEN   (XLEN),
      .CLSIZE (CLSIZE)
   ) u_packer (
      .clk   (clk_i),
      .rst   (rst_i),
      .clr   (beat_clr),
      .wr    (beat_ok),
      .wdata (m_rdata_i),
      .line  (c_data_o),
      .beat  (beat)
   );

   // Request/burst sequencing; every control output is registered here.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= S_IDLE;
         c_ready_o   <= 1'b0;
         err_o       <= 1'b0;
         m_arvalid_o <= 1'b0;
         m_rready_o  <= 1'b0;
         m_araddr_o  <= '0;
      end else begin
         c_ready_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (c_strobe_i) begin
                  m_araddr_o  <= {c_addr_i[XLEN-1:LINE_OFS], {LINE_OFS{1'b0}}};
                  m_arvalid_o <= 1'b1;
                  state       <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (m_arready_i) begin
                  m_arvalid_o <= 1'b0;
                  m_rready_o  <= 1'b1;
                  state       <= S_DATA;
               end
            end
            S_DATA: begin
               if (beat_ok) begin
                  if (m_rresp_i != RESP_OKAY) err_o <= 1'b1;
                  // Finish on the last counted beat or an early rlast;
                  // any disagreement between the two is a protocol error.
                  if (last || m_rlast_i) begin
                     if (last != m_rlast_i) err_o <= 1'b1;
                     m_rready_o <= 1'b0;
                     c_ready_o  <= 1'b1;
                     state      <= S_DONE;
                  end
               end
            end
            S_DONE:  state <= S_HOLD;
            // Swallows the cache's registered strobe still high after ready.
            S_HOLD:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_icache_line_fetcher.sv
// Directed bench with AR/line scoreboards checked by a negedge monitor.
module tb_icache_line_fetcher;

   logic         clk;
   logic         rst;
   logic         c_strobe;
   logic [31:0]  c_addr;
   logic         c_ready;
   logic [255:0] c_data;
   logic         err;
   logic [31:0]  araddr;
   logic [7:0]   arlen;
   logic [1:0]   arburst;
   logic [2:0]   arsize;
   logic         arvalid;
   logic         arready;
   logic [31:0]  rdata;
   logic [1:0]   rresp;
   logic         rlast;
   logic         rvalid;
   logic         rready;

   icache_line_fetcher #(.XLEN(32), .CLSIZE(256)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .c_strobe_i  (c_strobe),
      .c_addr_i    (c_addr),
      .c_ready_o   (c_ready),
      .c_data_o    (c_data),
      .err_o       (err),
      .m_araddr_o  (araddr),
      .m_arlen_o   (arlen),
      .m_arburst_o (arburst),
      .m_arsize_o  (arsize),
      .m_arvalid_o (arvalid),
      .m_arready_i (arready),
      .m_rdata_i   (rdata),
      .m_rresp_i   (rresp),
      .m_rlast_i   (rlast),
      .m_rvalid_i  (rvalid),
      .m_rready_o  (rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [255:0] L1 =
      256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;
   localparam logic [255:0] L3 =
      256'hA0000000_A0000001_A0000002_A0000003_A0000004_A0000005_A0000006_A0000007;
   localparam logic [255:0] LB =
      256'hB0000000_B0000001_B0000002_B0000003_B0000004_B0000005_00000000_00000000;
   localparam logic [255:0] LB_EXP =
      256'hB0000000_B0000001_B0000002_B0000003_B0000004_B0000005_A0000006_A0000007;

   int checks = 0;
   int errors = 0;
   int ready_cnt = 0;
   int ar_cnt = 0;

   logic [31:0]  q_ar[$];
   logic [255:0] q_line[$];
   logic         q_err[$];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got no/unexpected event, expected a valid one", name);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: AR handshakes, AR stability under stall, line deliveries.
   logic        prev_stall = 1'b0;
   logic        prev_ready = 1'b0;
   logic [31:0] prev_addr  = '0;
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
         prev_ready = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("ar_hold_valid", 256'(arvalid), 256'(1));
            chk("ar_hold_addr", 256'(araddr), 256'(prev_addr));
         end
         if (arvalid && arready) begin
            ar_cnt++;
            if (q_ar.size() == 0) fail("ar_unexpected");
            else chk("araddr", 256'(araddr), 256'(q_ar.pop_front()));
         end
         prev_stall = arvalid && !arready;
         prev_addr  = araddr;
         if (c_ready) begin
            ready_cnt++;
            chk("ready_single", 256'(prev_ready), 256'(0));
            if (q_line.size() == 0) fail("ready_unexpected");
            else begin
               chk("line", c_data, q_line.pop_front());
               chk("err", 256'(err), 256'(q_err.pop_front()));
            end
         end
         prev_ready = c_ready;
      end
   end

   task automatic request(input logic [31:0] a, input int ar_delay, input logic hold);
      int w;
      c_strobe = 1'b1;
      c_addr   = a;
      step();
      w = 0;
      while (!arvalid && w < 20) begin step(); w++; end
      if (!arvalid) fail("arvalid_timeout");
      if (!hold) c_strobe = 1'b0;
      repeat (ar_delay) step();
      arready = 1'b1;
      step();
      arready = 1'b0;
   endtask

   task automatic send_beats(input logic [255:0] words, input int nb, input int gap,
                             input int err_beat, input int last_beat);
      int w;
      for (int i = 0; i < nb; i++) begin
         rvalid = 1'b1;
         rdata  = words[255 - 32*i -: 32];
         rresp  = (i == err_beat) ? 2'b10 : 2'b00;
         rlast  = (i == last_beat);
         w = 0;
         while (!rready && w < 50) begin step(); w++; end
         if (!rready) fail("rready_timeout");
         step();
         rvalid = 1'b0;
         rlast  = 1'b0;
         rresp  = 2'b00;
         if (i < nb - 1) repeat (gap) step();
      end
   endtask

   task automatic wait_ready();
      int w;
      w = 0;
      while (!c_ready && w < 50) begin step(); w++; end
      if (!c_ready) fail("ready_timeout");
   endtask

   task automatic txn(input logic [31:0] a, input logic [31:0] exp_a,
                      input logic [255:0] words, input int nb,
                      input logic [255:0] exp_line, input logic exp_err,
                      input int ar_delay, input int gap, input int err_beat,
                      input int last_beat);
      q_ar.push_back(exp_a);
      q_line.push_back(exp_line);
      q_err.push_back(exp_err);
      request(a, ar_delay, 1'b0);
      send_beats(words, nb, gap, err_beat, last_beat);
      wait_ready();
      step();
      step();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ready"},   256'(c_ready), 256'(0));
      chk({tag, "_data"},    c_data, 256'(0));
      chk({tag, "_err"},     256'(err), 256'(0));
      chk({tag, "_arvalid"}, 256'(arvalid), 256'(0));
      chk({tag, "_rready"},  256'(rready), 256'(0));
      chk({tag, "_araddr"},  256'(araddr), 256'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; c_strobe = 1'b0; c_addr = '0; arready = 1'b0;
      rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
      #3;
      check_reset_outputs("reset");
      chk("arlen",   256'(arlen),   256'(7));
      chk("arburst", 256'(arburst), 256'(1));
      chk("arsize",  256'(arsize),  256'(2));
      step(); step();
      rst = 1'b0;
      step();

      // basic miss
      txn(32'h0000_1234, 32'h0000_1220, L1, 8, L1, 1'b0, 0, 0, -1, 7);
      // AR backpressure and gapped beats
      txn(32'h0000_ABCD, 32'h0000_ABC0, L1, 8, L1, 1'b0, 5, 2, -1, 7);

      // held strobe: second AR only once HOLD has passed
      q_ar.push_back(32'h0000_2000); q_line.push_back(L3); q_err.push_back(1'b0);
      request(32'h0000_2000, 0, 1'b1);
      send_beats(L3, 8, 0, -1, 7);
      wait_ready();
      step(); chk("hold_no_ar", 256'(arvalid), 256'(0));
      step(); chk("idle_no_ar", 256'(arvalid), 256'(0));
      step(); chk("held_new_ar", 256'(arvalid), 256'(1));
      c_strobe = 1'b0;
      q_ar.push_back(32'h0000_2000); q_line.push_back(L3); q_err.push_back(1'b0);
      request(32'h0000_2000, 0, 1'b0);
      send_beats(L3, 8, 0, -1, 7);
      wait_ready();
      step(); step();

      // SLVERR on beat 3, then sticky across a clean request
      txn(32'h0000_3000, 32'h0000_3000, L1, 8, L1, 1'b1, 0, 0, 3, 7);
      txn(32'h0000_3024, 32'h0000_3020, L3, 8, L3, 1'b1, 0, 0, -1, 7);

      // async reset after beat 4
      q_ar.push_back(32'h0000_4000);
      request(32'h0000_4000, 0, 1'b0);
      send_beats(L1, 5, 0, -1, -1);
      #2 rst = 1'b1;
      #1 check_reset_outputs("midreset");
      step(); step();
      rst = 1'b0;
      step();

      // clean after reset, then early rlast on beat 5
      txn(32'h0000_5008, 32'h0000_5000, L3, 8, L3, 1'b0, 0, 0, -1, 7);
      txn(32'h0000_6000, 32'h0000_6000, LB, 6, LB_EXP, 1'b1, 0, 0, -1, 5);

      // fresh reset, then missing rlast on beat 7
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      txn(32'h0000_7000, 32'h0000_7000, L1, 8, L1, 1'b1, 0, 0, -1, -1);

      repeat (4) step();
      chk("ready_count", 256'(ready_cnt), 256'(9));
      chk("ar_count", 256'(ar_cnt), 256'(10));
      chk("q_line_empty", 256'(q_line.size()), 256'(0));
      chk("q_ar_empty", 256'(q_ar.size()), 256'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
